fp4_cmul_pipe: RTL and testbench
================================

Name: fp4_cmul_pipe

Overview:
- Registered complex multiplier for 4-bit floating-point samples in E2M1 format (1 sign, 2 exponent with bias 1, 1 mantissa bit; no Inf/NaN).
- Computes (a + jb)·(c + jd) and returns out_real + j·out_imag in the same format, one cycle after a valid input.
- Serves as the twiddle-multiply stage of the FFT butterfly datapath.

Parameters:
- None. The format is fixed at E2M1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operands a, b, c, d are valid this cycle
- a  input  4  real part of z1 (E2M1)
- b  input  4  imaginary part of z1
- c  input  4  real part of z2
- d  input  4  imaginary part of z2
- out_valid  output  1  out_real and out_imag hold a new result
- out_real  output  4  round(a·c − b·d), E2M1
- out_imag  output  4  round(a·d + b·c), E2M1

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is asynchronous and active-high.
- Encoding, with magnitude set by bits [2:0]:
  - 000 = 0.0, 001 = 0.5 (subnormal), 010 = 1.0, 011 = 1.5.
  - 100 = 2.0, 101 = 3.0, 110 = 4.0, 111 = 6.0.
  - Bit 3 is the sign.
  - Code 1000 (−0) is accepted as an input and treated as 0.
- Arithmetic:
  - Decode each operand to signed fixed point in units of 0.5.
  - Form the four products exactly in units of 0.25; max |product| = 36.
  - Form the real and imaginary sums exactly in at least 10-bit signed quarter units; range ±72.
  - Round once, at the end. There is no intermediate rounding.
- Conversion back to E2M1:
  - Round to nearest representable magnitude; ties go to the even mantissa code (LSB 0).
  - Tie results: 0.25→0, 0.75→1.0, 1.25→1.0, 1.75→2.0, 2.5→2.0, 3.5→4.0, 5.0→4.0.
  - |x| > 5.0 saturates to ±6.0 (code s111). There is no wrap.
  - A zero result (exact zero, or rounded to zero) is always emitted as 0000, never 1000.
- Timing:
  - Latency is 1 cycle. When in_valid=1 at a rising edge, out_real and out_imag are loaded and out_valid=1 after that edge.
  - When in_valid=0, out_valid=0 and out_real/out_imag hold their previous values.
  - Back-to-back valid inputs give one result per cycle. There is no stall and no backpressure.
- Reset:
  - rst=1 immediately forces out_valid=0, out_real=0000, out_imag=0000, regardless of clk.
  - When reset asserts mid-stream, the in-flight result is discarded.
  - The first capture occurs on the first rising edge with rst=0 and in_valid=1.
- Operands are pure combinational inputs to the capture register. X-free output is required whenever the inputs are known.

Optional Feature:
- Macro FP4_CMUL_SAT_FLAGS_EN.
- When defined:
  - Adds output ports sat_real and sat_imag, 1 bit each.
  - Each flag is registered alongside its result and set when the exact unrounded sum had |x| > 6.0, i.e. clipping occurred. Exactly 6.0 does not set the flag.
  - The flags reset to 0 and hold their value when in_valid=0.
- When not defined: the ports are absent and the datapath is identical.

Test Plan:
- (1+j0)·(1+j0): a=0010, b=0000, c=0010, d=0000, in_valid=1 → next cycle out_real=0010, out_imag=0000, out_valid=1.
- Two more exact cases:
  - (0+j1)·(0+j1) → out_real=1010 (−1.0), out_imag=0000.
  - (1+j0)·(0+j1) → out_real=0000, out_imag=0010.
- Cancellation and scaling:
  - (1+j1)·(1−j1): d=1010 → out_real=0100 (2.0), out_imag=0000 with positive zero.
  - (1.5+j0)·(0+j2): a=0011, d=0100 → out_real=0000, out_imag=0101 (3.0).
- Rounding and saturation:
  - (6+j6)·(6−j6): a=b=c=0111, d=1111. Real = 72 → out_real=0111, sat_real=1 if the macro is enabled; imag = 0 → out_imag=0000.
  - (0.5+j0)·(0.5+j0) → 0.25 ties to 0000.
  - (1.5+j0)·(1.5+j0) → 2.25 rounds to 0100.
  - (1.5+j0)·(3+j0) → 4.5 rounds to 0110.
- Control:
  - Assert rst asynchronously between edges while out_valid=1 → outputs clear to 0 immediately.
  - Drop in_valid for 2 cycles → out_valid=0 and data held.
  - Then 3 back-to-back valid inputs → 3 consecutive out_valid pulses with matching results.

Source files
------------

// File: rtl/fp4_cmul_pipe_if.sv
// Operand/result bundle for the E2M1 complex multiplier.
// With FP4_CMUL_SAT_FLAGS_EN defined, per-component saturation flags are added.
interface fp4_cmul_pipe_if;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    logic       out_valid;
    logic [3:0] out_real;
    logic [3:0] out_imag;
`ifdef FP4_CMUL_SAT_FLAGS_EN
    logic       sat_real;
    logic       sat_imag;

    modport master (output in_valid, a, b, c, d,
                    input  out_valid, out_real, out_imag, sat_real, sat_imag);
    modport slave  (input  in_valid, a, b, c, d,
                    output out_valid, out_real, out_imag, sat_real, sat_imag);
`else
    modport master (output in_valid, a, b, c, d,
                    input  out_valid, out_real, out_imag);
    modport slave  (input  in_valid, a, b, c, d,
                    output out_valid, out_real, out_imag);
`endif
endinterface

// File: rtl/fp4_cmul_pipe.sv
// Registered E2M1 complex multiplier: (a+jb)(c+jd), one cycle latency.
// Exact quarter-unit arithmetic, single round-to-nearest-even at the end,
// saturation to +/-6.0. Optional macro FP4_CMUL_SAT_FLAGS_EN adds
// registered clipping flags sat_real / sat_imag.
module fp4_cmul_pipe (
    input  logic           clk,
    input  logic           rst,
    fp4_cmul_pipe_if.slave bus
);

    // E2M1 code -> signed value in half units (-0 decodes to 0)
    function automatic logic signed [9:0] dec(input logic [3:0] x);
        logic signed [9:0] m;
        case (x[2:0])
            3'd0:    m = 10'sd0;
            3'd1:    m = 10'sd1;
            3'd2:    m = 10'sd2;
            3'd3:    m = 10'sd3;
            3'd4:    m = 10'sd4;
            3'd5:    m = 10'sd6;
            3'd6:    m = 10'sd8;
            default: m = 10'sd12;
        endcase
        return x[3] ? -m : m;
    endfunction

    // Magnitude of a quarter-unit sum
    function automatic logic [9:0] mag(input logic signed [9:0] s);
        logic [9:0] q;
        q = s[9] ? 10'(-s) : 10'(s);
        return q;
    endfunction

    // Quarter-unit sum -> E2M1; thresholds encode the tie-to-even points
    // (0.25->0, 0.75->1.0, 1.25->1.0, 1.75->2.0, 2.5->2.0, 3.5->4.0, 5.0->4.0)
    function automatic logic [3:0] enc(input logic signed [9:0] s);
        logic [9:0] q;
        logic [2:0] e;
        q = mag(s);
        if      (q <= 10'd1)  e = 3'd0;
        else if (q == 10'd2)  e = 3'd1;
        else if (q <= 10'd5)  e = 3'd2;
        else if (q == 10'd6)  e = 3'd3;
        else if (q <= 10'd10) e = 3'd4;
        else if (q <= 10'd13) e = 3'd5;
        else if (q <= 10'd20) e = 3'd6;
        else                  e = 3'd7;
        // zero never carries a sign
        return {s[9] && (e != 3'd0), e};
    endfunction

    logic signed [9:0] a_h, b_h, c_h, d_h;
    logic signed [9:0] sum_re, sum_im;

    logic       out_valid_d, out_valid_q;
    logic [3:0] out_real_d,  out_real_q;
    logic [3:0] out_imag_d,  out_imag_q;
`ifdef FP4_CMUL_SAT_FLAGS_EN
    logic       sat_real_d,  sat_real_q;
    logic       sat_imag_d,  sat_imag_q;
`endif

    // Exact products (|p| <= 144 quarter units) and sums (|s| <= 288)
    always_comb begin
        a_h    = dec(bus.a);
        b_h    = dec(bus.b);
        c_h    = dec(bus.c);
        d_h    = dec(bus.d);
        sum_re = (a_h * c_h) - (b_h * d_h);
        sum_im = (a_h * d_h) + (b_h * c_h);
    end

    // Load on in_valid, otherwise hold data and drop valid
    always_comb begin
        out_valid_d = bus.in_valid;
        out_real_d  = out_real_q;
        out_imag_d  = out_imag_q;
`ifdef FP4_CMUL_SAT_FLAGS_EN
        sat_real_d  = sat_real_q;
        sat_imag_d  = sat_imag_q;
`endif
        if (bus.in_valid) begin
            out_real_d = enc(sum_re);
            out_imag_d = enc(sum_im);
`ifdef FP4_CMUL_SAT_FLAGS_EN
            // clipping means strictly above 6.0 (24 quarter units)
            sat_real_d = mag(sum_re) > 10'd24;
            sat_imag_d = mag(sum_im) > 10'd24;
`endif
        end
    end

    // Result register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_real_q  <= 4'd0;
            out_imag_q  <= 4'd0;
`ifdef FP4_CMUL_SAT_FLAGS_EN
            sat_real_q  <= 1'b0;
            sat_imag_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
`ifdef FP4_CMUL_SAT_FLAGS_EN
            sat_real_q  <= sat_real_d;
            sat_imag_q  <= sat_imag_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_real  = out_real_q;
    assign bus.out_imag  = out_imag_q;
`ifdef FP4_CMUL_SAT_FLAGS_EN
    assign bus.sat_real  = sat_real_q;
    assign bus.sat_imag  = sat_imag_q;
`endif

endmodule

// File: tb/tb_fp4_cmul_pipe.sv
// Scoreboard bench for fp4_cmul_pipe: the driver queues expected results,
// a negedge monitor pops and compares on out_valid and checks hold/reset.
module tb_fp4_cmul_pipe;

    typedef struct packed {
        logic [3:0] re;
        logic [3:0] im;
        logic       sr;
        logic       si;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    exp_t last;

    fp4_cmul_pipe_if bus ();

    fp4_cmul_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic chk_flags(input string name, input logic sr, input logic si);
`ifdef FP4_CMUL_SAT_FLAGS_EN
        chk({name, ".sat_real"}, {3'b0, bus.sat_real}, {3'b0, sr});
        chk({name, ".sat_imag"}, {3'b0, bus.sat_imag}, {3'b0, si});
`endif
    endtask

    // Drive one operand set for a single edge and queue its expected result
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] d, input logic [3:0] re, input logic [3:0] im,
                         input logic sr);
        exp_t e;
        e.re = re; e.im = im; e.sr = sr; e.si = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = a; bus.b = b; bus.c = c; bus.d = d;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Monitor: compare on out_valid, otherwise check held / reset values
    initial begin
        exp_t e;
        last = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = '0;
                chk("rst.out_valid", {3'b0, bus.out_valid}, 4'd0);
                chk("rst.out_real", bus.out_real, 4'd0);
                chk("rst.out_imag", bus.out_imag, 4'd0);
            end else if (bus.out_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_real", bus.out_real, e.re);
                    chk("out_imag", bus.out_imag, e.im);
                    chk_flags("res", e.sr, e.si);
                    last = e;
                end
            end else begin
                chk("hold.out_real", bus.out_real, last.re);
                chk("hold.out_imag", bus.out_imag, last.im);
                chk_flags("hold", last.sr, last.si);
            end
        end
    end

    // Global run bound
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.a = 4'd0; bus.b = 4'd0; bus.c = 4'd0; bus.d = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // back-to-back directed vectors: a, b, c, d -> real, imag, sat_real
        issue(4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0); // 1*1
        issue(4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b1010, 4'b0000, 1'b0); // j*j = -1
        issue(4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 1'b0); // 1*j
        issue(4'b0010, 4'b0010, 4'b0010, 4'b1010, 4'b0100, 4'b0000, 1'b0); // (1+j)(1-j)
        issue(4'b0011, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0101, 1'b0); // 1.5*2j
        issue(4'b0111, 4'b0111, 4'b0111, 4'b1111, 4'b0111, 4'b0000, 1'b1); // 72 -> sat
        issue(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0); // 0.25 -> 0
        issue(4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0100, 4'b0000, 1'b0); // 2.25 -> 2
        issue(4'b0011, 4'b0000, 4'b0101, 4'b0000, 4'b0110, 4'b0000, 1'b0); // 4.5 -> 4

        // idle two cycles: monitor checks held data
        repeat (2) @(posedge clk);
        #1;

        issue(4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0); // -0 input
        issue(4'b1011, 4'b0000, 4'b0001, 4'b0000, 4'b1010, 4'b0000, 1'b0); // -0.75 -> -1
        issue(4'b0100, 4'b0000, 4'b0101, 4'b0000, 4'b0111, 4'b0000, 1'b0); // exactly 6.0
        issue(4'b0100, 4'b0101, 4'b0010, 4'b1010, 4'b0110, 4'b0010, 1'b0); // 5.0 -> 4, imag 1
        @(posedge clk); #1;

        // async reset while out_valid is high; in-flight result discarded
        issue(4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0);
        #2 rst = 1'b1;
        sb_q.delete();
        #1;
        chk("async_rst.out_valid", {3'b0, bus.out_valid}, 4'd0);
        chk("async_rst.out_real", bus.out_real, 4'd0);
        chk("async_rst.out_imag", bus.out_imag, 4'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // three back-to-back results after reset
        issue(4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b1010, 4'b0000, 1'b0);
        issue(4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0100, 4'b0000, 1'b0);
        issue(4'b0010, 4'b0010, 4'b0010, 4'b1010, 4'b0100, 4'b0000, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 4'(sb_q.size()), 4'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
